// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t       : controller state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package seq_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_subtractor.sv
// Ripple-borrow subtractor: difference = a - b, built from a full-subtractor chain.
//   a, b       : W-bit minuend / subtrahend
//   difference : W-bit result (modulo 2^W)
//   borrow_out : 1 when a < b (result would be negative)
module ripple_borrow_subtractor #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] difference,
  output logic         borrow_out
);

  // Borrow ripples LSB to MSB through a block-local variable.
  always_comb begin
    logic br;
    br         = 1'b0;
    difference = '0;
    for (int i = 0; i < int'(W); i++) begin
      difference[i] = a[i] ^ b[i] ^ br;
      br            = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    borrow_out = br;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
//   clk, reset          : clock, synchronous active-high reset
//   start               : division request, accepted only in IDLE
//   dividend, divisor   : unsigned operands, captured on an accepted start
//   busy                : high while iterating (RUN)
//   done                : one-cycle pulse, results valid
//   quotient, remainder : registered results, held until the next result
//   div_by_zero         : registered flag accompanying the results
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t state, next_state;

  logic [RW-1:0]    rem;        // partial remainder
  logic [RW-1:0]    dvs;        // captured divisor, zero-extended
  logic [WIDTH-1:0] quo;        // quotient shift register (starts as dividend)
  logic [CW-1:0]    cnt;        // iterations left
  logic             zero_pend;  // current DONE visit came from a divide-by-zero

  logic [RW-1:0] shifted_c;
  logic [RW-1:0] diff_c;
  logic          borrow_c;
  logic          zero_div_c;
  logic          last_iter_c;
  logic          load_run_c;
  logic          load_zero_c;
  logic          iter_c;
  logic          publish_c;

  assign zero_div_c  = (divisor == '0);
  assign last_iter_c = (cnt == CW'(1));

  // {rem, quo} shifted left by one; rem's MSB is always 0 here so truncation is lossless.
  assign shifted_c = RW'({rem, quo[WIDTH-1]});

  ripple_borrow_subtractor #(
    .W (RW)
  ) u_sub (
    .a          (shifted_c),
    .b          (dvs),
    .difference (diff_c),
    .borrow_out (borrow_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = zero_div_c ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_iter_c) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Control decode. A divide-by-zero publishes on the accepting edge; a normal
  // division publishes on the edge that leaves DONE.
  always_comb begin
    load_run_c  = 1'b0;
    load_zero_c = 1'b0;
    iter_c      = 1'b0;
    publish_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_zero_c = zero_div_c;
          load_run_c  = ~zero_div_c;
        end
      end
      ST_RUN:  iter_c    = 1'b1;
      ST_DONE: publish_c = ~zero_pend;
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem         <= '0;
      dvs         <= '0;
      quo         <= '0;
      cnt         <= '0;
      zero_pend   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (next_state == ST_RUN);
      done <= load_zero_c | publish_c;

      if (load_run_c) begin
        rem       <= '0;
        quo       <= dividend;
        dvs       <= RW'(divisor);
        cnt       <= CW'(WIDTH);
        zero_pend <= 1'b0;
      end

      if (load_zero_c) begin
        zero_pend   <= 1'b1;
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end

      // Restoring step: keep the shifted value on borrow, else take the difference.
      if (iter_c) begin
        rem <= borrow_c ? shifted_c : diff_c;
        quo <= WIDTH'({quo, ~borrow_c});
        cnt <= cnt - CW'(1);
      end

      if (publish_c) begin
        quotient    <= quo;
        remainder   <= rem[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
